// File: rtl/pc_control_pkg.sv
// Shared definitions for the PC stage: FSM state encodings and default widths/vectors,
// kept in one place so the fetch and control FSMs agree with pc_control.
package pc_control_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pc_state_t;

    localparam int          PC_ADDR_W    = 16;
    localparam int          PC_DISP_W    = 8;
    localparam logic [15:0] PC_RESET_VEC = 16'h0000;

    // Wide enough for FLUSH_CYCLES up to 15.
    localparam int          FLUSH_CNT_W  = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: picks register target, PC-relative target or sequential PC.
// Purely combinational; all sums wrap modulo 2^ADDR_W.
module pc_next_sel
    import pc_control_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter int DISP_W = PC_DISP_W
)(
    input  logic [ADDR_W-1:0] pc,
    input  logic [DISP_W-1:0] disp,
    input  logic [ADDR_W-1:0] jtarget,
    input  logic              br_req,
    input  logic              jmp_req,
    input  logic              branch,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] seq_pc,
    output logic              taken
);

    logic [ADDR_W-1:0] disp_ext;

    assign disp_ext = {{(ADDR_W-DISP_W){disp[DISP_W-1]}}, disp};
    assign seq_pc   = pc + ADDR_W'(1);
    assign taken    = branch & (br_req | jmp_req);

    // Register-target jumps win over PC-relative branches when both are requested.
    always_comb begin
        next_pc = seq_pc;
        if (jmp_req && branch) begin
            next_pc = jtarget;
        end else if (br_req && branch) begin
            next_pc = pc + disp_ext;
        end
    end

endmodule

// File: rtl/pc_control.sv
// Program-counter stage: holds the PC, advances or redirects it, and on every redirect
// raises a one-cycle flush/redirect pulse followed by an invalid-fetch window.
module pc_control
    import pc_control_pkg::*;
#(
    parameter int                ADDR_W       = PC_ADDR_W,
    parameter int                DISP_W       = PC_DISP_W,
    parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(PC_RESET_VEC),
    parameter int                FLUSH_CYCLES = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              br_req,
    input  logic              jmp_req,
    input  logic              link_req,
    input  logic              branch,
    input  logic [DISP_W-1:0] disp,
    input  logic [ADDR_W-1:0] jtarget,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic [ADDR_W-1:0] link_addr,
    output logic              redirect
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pc_state_t               state;
    pc_state_t               state_nxt;
    logic [FLUSH_CNT_W-1:0]  flush_cnt;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_nxt;
    logic [ADDR_W-1:0]       next_pc;
    logic [ADDR_W-1:0]       seq_pc;
    logic                    taken;
    logic                    advance;
    logic                    redirect_now;

    pc_next_sel #(
        .ADDR_W (ADDR_W),
        .DISP_W (DISP_W)
    ) u_next_sel (
        .pc      (pc),
        .disp    (disp),
        .jtarget (jtarget),
        .br_req  (br_req),
        .jmp_req (jmp_req),
        .branch  (branch),
        .next_pc (next_pc),
        .seq_pc  (seq_pc),
        .taken   (taken)
    );

    assign advance      = (state == RUN) && pc_en;
    assign redirect_now = advance && taken;
    assign pc_valid     = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // FLUSH is left on the cycle the counter is already zero, so it lasts FLUSH_CYCLES cycles.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (redirect_now) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt     = BOOT;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_VEC;
            link_addr <= '0;
            flush     <= 1'b0;
            redirect  <= 1'b0;
        end else begin
            flush    <= redirect_now;
            redirect <= redirect_now;
            if (advance) begin
                pc <= next_pc;
            end
            // Return address is captured for JAL whether or not the jump is taken.
            if (advance && link_req && jmp_req) begin
                link_addr <= seq_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: two instances (1- and 3-cycle flush windows) checked
// every cycle against a cycle-level behavioural model, plus directed literal checks.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic        br_req;
    logic        jmp_req;
    logic        link_req;
    logic        branch;
    logic [7:0]  disp;
    logic [15:0] jtarget;

    logic [15:0] pc1, link1, pc3, link3;
    logic        valid1, flush1, redir1, valid3, flush3, redir3;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    pc_control #(.FLUSH_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .br_req(br_req), .jmp_req(jmp_req),
        .link_req(link_req), .branch(branch), .disp(disp), .jtarget(jtarget),
        .pc(pc1), .pc_valid(valid1), .flush(flush1), .link_addr(link1), .redirect(redir1)
    );

    pc_control #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .pc_en(pc_en), .br_req(br_req), .jmp_req(jmp_req),
        .link_req(link_req), .branch(branch), .disp(disp), .jtarget(jtarget),
        .pc(pc3), .pc_valid(valid3), .flush(flush3), .link_addr(link3), .redirect(redir3)
    );

    always #5 clk = ~clk;

    // Model: count of remaining invalid cycles replaces any notion of FSM states.
    int          m_flen [2] = '{1, 3};
    logic [15:0] m_pc   [2];
    logic [15:0] m_link [2];
    int          m_inv  [2];
    bit          m_pulse[2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_pc[i]    <= 16'h0000;
                m_link[i]  <= 16'h0000;
                m_inv[i]   <= 1;
                m_pulse[i] <= 1'b0;
            end else if (m_inv[i] > 0) begin
                m_inv[i]   <= m_inv[i] - 1;
                m_pulse[i] <= 1'b0;
            end else begin
                m_pulse[i] <= 1'b0;
                if (pc_en) begin
                    if (link_req && jmp_req) m_link[i] <= 16'(int'(m_pc[i]) + 1);
                    if (jmp_req && branch) begin
                        m_pc[i]    <= jtarget;
                        m_inv[i]   <= m_flen[i];
                        m_pulse[i] <= 1'b1;
                    end else if (br_req && branch) begin
                        m_pc[i]    <= 16'(int'(m_pc[i]) + int'($signed(disp)));
                        m_inv[i]   <= m_flen[i];
                        m_pulse[i] <= 1'b1;
                    end else begin
                        m_pc[i]    <= 16'(int'(m_pc[i]) + 1);
                    end
                end
            end
        end
    end

    task automatic cmp_field(input string name, input int inst,
                             input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (inst %0d) at %0t: actual=%h required=%h",
                     name, inst, $time, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
        cmp_field(name, 0, act, exp);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp_field("pc",        1, pc1,           m_pc[0]);
            cmp_field("pc_valid",  1, 16'(valid1),   16'(m_inv[0] == 0));
            cmp_field("flush",     1, 16'(flush1),   16'(m_pulse[0]));
            cmp_field("redirect",  1, 16'(redir1),   16'(m_pulse[0]));
            cmp_field("link_addr", 1, link1,         m_link[0]);
            cmp_field("pc",        3, pc3,           m_pc[1]);
            cmp_field("pc_valid",  3, 16'(valid3),   16'(m_inv[1] == 0));
            cmp_field("flush",     3, 16'(flush3),   16'(m_pulse[1]));
            cmp_field("redirect",  3, 16'(redir3),   16'(m_pulse[1]));
            cmp_field("link_addr", 3, link3,         m_link[1]);
        end
    end

    // Inputs change 2 time units after the rising edge and are held across the next one.
    task automatic apply_stimulus(input logic en, input logic br, input logic jmp,
                                  input logic lnk, input logic b,
                                  input logic [7:0] d, input logic [15:0] jt);
        pc_en = en; br_req = br; jmp_req = jmp; link_req = lnk; branch = b;
        disp = d; jtarget = jt;
        @(posedge clk);
        #2;
    endtask

    task automatic set_pc(input logic [15:0] target);
        apply_stimulus(1, 0, 1, 0, 1, 8'h00, target);
        apply_stimulus(1, 1, 0, 0, 1, 8'h40, 16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        pc_en = 0; br_req = 0; jmp_req = 0; link_req = 0; branch = 0;
        disp = 8'h00; jtarget = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        check_en = 1'b1;
        check_output("reset_pc",    pc1,          16'h0000);
        check_output("reset_valid", 16'(valid1),  16'h0000);
        check_output("reset_flush", 16'(flush1),  16'h0000);
        check_output("reset_link",  link1,        16'h0000);

        reset = 1'b0;
        check_output("boot_valid", 16'(valid1), 16'h0000);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        check_output("run_pc0", pc1, 16'h0000);
        check_output("run_valid", 16'(valid1), 16'h0001);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        check_output("run_pc1", pc1, 16'h0001);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        check_output("run_pc2", pc1, 16'h0002);

        set_pc(16'h0010);
        check_output("setup_pc", pc1, 16'h0010);
        apply_stimulus(1, 1, 0, 0, 1, 8'hFC, 16'h0000);
        check_output("br_back_pc",    pc1,          16'h000C);
        check_output("br_back_flush", 16'(flush1),  16'h0001);
        check_output("br_back_redir", 16'(redir1),  16'h0001);
        check_output("br_back_valid", 16'(valid1),  16'h0000);
        apply_stimulus(1, 1, 0, 0, 1, 8'h22, 16'h0000);
        check_output("flush_ignore_pc", pc1,         16'h000C);
        check_output("flush_end_valid", 16'(valid1), 16'h0001);
        check_output("flush_end_pulse", 16'(flush1), 16'h0000);

        set_pc(16'h0010);
        apply_stimulus(1, 1, 0, 0, 0, 8'hFC, 16'h0000);
        check_output("not_taken_pc",    pc1,         16'h0011);
        check_output("not_taken_flush", 16'(flush1), 16'h0000);
        check_output("not_taken_valid", 16'(valid1), 16'h0001);

        set_pc(16'h0020);
        apply_stimulus(1, 1, 1, 1, 1, 8'h05, 16'h1234);
        check_output("jal_pc",   pc1,   16'h1234);
        check_output("jal_link", link1, 16'h0021);
        apply_stimulus(0, 0, 0, 0, 0, 8'h00, 16'h0000);

        set_pc(16'hFFFF);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        check_output("wrap_pc", pc1, 16'h0000);
        apply_stimulus(0, 1, 1, 1, 1, 8'h08, 16'h4444);
        apply_stimulus(0, 1, 1, 1, 1, 8'h08, 16'h4444);
        check_output("hold_pc",    pc1,         16'h0000);
        check_output("hold_flush", 16'(flush1), 16'h0000);
        check_output("hold_link",  link1,       16'h0021);

        repeat (4) apply_stimulus(0, 0, 0, 0, 0, 8'h00, 16'h0000);
        apply_stimulus(1, 1, 0, 0, 1, 8'h10, 16'h0000);
        cmp_field("flush_pulse", 3, 16'(flush3), 16'h0001);
        apply_stimulus(0, 0, 0, 0, 0, 8'h00, 16'h0000);
        cmp_field("mid_flush_valid", 3, 16'(valid3), 16'h0000);
        reset = 1'b1;
        #1;
        cmp_field("async_reset_pc",    3, pc3,          16'h0000);
        cmp_field("async_reset_valid", 3, 16'(valid3),  16'h0000);
        cmp_field("async_reset_flush", 3, 16'(flush3),  16'h0000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cmp_field("boot_after_reset", 3, 16'(valid3), 16'h0000);
        apply_stimulus(1, 0, 0, 0, 0, 8'h00, 16'h0000);
        cmp_field("run_after_reset_valid", 3, 16'(valid3), 16'h0001);
        cmp_field("run_after_reset_pc",    3, pc3,         16'h0000);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] jt;
            reset = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0:       jt = 16'hFFFF;
                1:       jt = 16'hFFF0 + 16'($urandom_range(0, 15));
                default: jt = 16'($urandom);
            endcase
            apply_stimulus(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                           1'($urandom), 1'($urandom), 8'($urandom), jt);
        end
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 8'h00, 16'h0000);
        @(negedge clk);
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
